// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP_WIDTH-bit CLA group per stage.
// Optional zero-result flag output enabled by defining CLA_ZERO_FLAG_EN.
module pipelined_cla_adder #(
  parameter int WIDTH       = 64,
  parameter int GROUP_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num_one,
  input  logic [WIDTH-1:0] num_two,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
`ifdef CLA_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int NG = WIDTH / GROUP_WIDTH;
  localparam int GW = GROUP_WIDTH;

  // Flat sum-of-products lookahead: c[i+1] = g_i | p_i g_{i-1} | ... | p_i..p_0 c0.
  function automatic logic [GW:0] group_carries(input logic [GW-1:0] g,
                                                input logic [GW-1:0] p,
                                                input logic          c0);
    logic [GW:0] c;
    logic        term;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < GW; i++) begin
      term = c0;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  // Handshake: a beat moves on a cycle where valid & ready are both high. The whole
  // pipe advances together (advance = !out_valid | out_ready); when it does not,
  // every stage, bubbles included, holds and in_ready is low.
  logic advance;

  // Index 0 is the entry point; index k+1 is the register output of stage k.
  logic             vld_w [NG+1];
  logic [WIDTH-1:0] a_w   [NG+1];
  logic [WIDTH-1:0] b_w   [NG+1];
  logic [WIDTH-1:0] res_w [NG+1];
  logic             c_w   [NG+1];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // B is inverted at entry for subtract so every stage only ever adds.
  assign vld_w[0] = in_valid;
  assign a_w[0]   = num_one;
  assign b_w[0]   = sub ? ~num_two : num_two;
  assign res_w[0] = '0;
  assign c_w[0]   = cin;

  for (genvar k = 0; k < NG; k++) begin : g_stage
    logic [GW-1:0]    ga;
    logic [GW-1:0]    gb;
    logic [GW-1:0]    gp;
    logic [GW-1:0]    gs;
    logic [GW:0]      gc;
    logic [WIDTH-1:0] res_d;

    logic             vld_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             c_q;

    assign ga = a_w[k][k*GW +: GW];
    assign gb = b_w[k][k*GW +: GW];
    assign gp = ga ^ gb;
    assign gc = group_carries(ga & gb, gp, c_w[k]);
    assign gs = gp ^ gc[GW-1:0];

    always_comb begin
      res_d               = res_w[k];
      res_d[k*GW +: GW]   = gs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        a_q   <= '0;
        b_q   <= '0;
        res_q <= '0;
        c_q   <= 1'b0;
      end else if (advance) begin
        vld_q <= vld_w[k];
        a_q   <= a_w[k];
        b_q   <= b_w[k];
        res_q <= res_d;
        c_q   <= gc[GW];
      end
    end

    assign vld_w[k+1] = vld_q;
    assign a_w[k+1]   = a_q;
    assign b_w[k+1]   = b_q;
    assign res_w[k+1] = res_q;
    assign c_w[k+1]   = c_q;

    if (k == NG - 1) begin : g_last
      // The last group contains the MSB, so its internal carry gc[GW-1] is the carry into the MSB.
      logic ovf_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= gc[GW] ^ gc[GW-1];
        end
      end

      assign overflow = ovf_q;

`ifdef CLA_ZERO_FLAG_EN
      logic zero_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          zero_q <= 1'b0;
        end else if (advance) begin
          zero_q <= ~|res_d;
        end
      end

      assign zero = zero_q;
`endif
    end
  end

  assign out_valid = vld_w[NG];
  assign sum       = res_w[NG];
  assign cout      = c_w[NG];

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined successor to the single-cycle n-bit carry-lookahead adder.
- Operands are split into GROUP_WIDTH-bit CLA groups. Each group is resolved in its own pipeline stage, and the group carry-out is registered into the next stage.
- Adds add/subtract mode, carry-in, signed overflow and a valid/ready handshake with backpressure.
- Sits in the 64-bit datapath wherever a sustained one-result-per-clock add stream at high clock rate is required.

Parameters:
- WIDTH, 64, operand width in bits; must be a multiple of GROUP_WIDTH and at least 2.
- GROUP_WIDTH, 16, bits per CLA group; NG = WIDTH/GROUP_WIDTH pipeline stages.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- num_one  input  WIDTH  operand A
- num_two  input  WIDTH  operand B
- cin  input  1  carry-in (add mode) / borrow-complement (sub mode)
- sub  input  1  0: A+B+cin; 1: A+~B+cin (pass cin=1 for true A-B)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result bits
- cout  output  1  carry out of MSB
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, out_valid, sum, cout and overflow are 0.
  - In-flight beats are discarded; no partial result ever appears after reset deasserts.
  - in_ready is 1 once rst_n is high.
- Stage k (k = 1..NG) holds:
  - a valid bit;
  - result bits [k*GW-1:0] already resolved;
  - unresolved operand bits of A and B' (B' = sub ? ~B : B, inverted at entry);
  - the registered carry into group k;
  - carry-into-MSB (final stage only).
- Group logic per stage:
  - g_i = a_i & b_i, p_i = a_i ^ b_i.
  - Lookahead c_{i+1} = g_i | p_i & c_i, flat within the group.
  - s_i = p_i ^ c_i.
- Stage 1 uses cin as group carry-in.
- Latency: exactly NG cycles from an accepted beat (in_valid & in_ready) to out_valid, when there is no stall. Throughput is 1 beat/cycle.
- Stall, global: advance = !out_valid | out_ready; in_ready = advance.
  - When advance=0 every stage holds its contents, including bubbles.
  - Bubbles are not compressed.
- Output hold: while out_valid & !out_ready, sum/cout/overflow and out_valid are stable.
- A beat offered while in_ready=0 is not captured. The source must hold it.
- A bubble (in_valid=0 on an advance cycle) enters stage 1 with valid=0.
- NG=1 (GROUP_WIDTH=WIDTH): one registered stage, latency 1.
- Arithmetic wrap:
  - sum is modulo 2^WIDTH.
  - cout = 1 on unsigned wrap (add), or on no-borrow (sub with cin=1).
- sub and cin are sampled with the operands and travel with the beat. Mode changes beat-to-beat are legal.

Optional Feature:
- CLA_ZERO_FLAG_EN
  - Defined: adds output port zero (1 bit), registered alongside sum. zero = 1 iff sum == 0. Reset value 0, held under stall like sum.
  - Undefined: port and logic absent; otherwise identical behaviour.

Test Plan (WIDTH=64, GROUP_WIDTH=16, latency 4):
- Full-width carry ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1, sub=0 -> after 4 cycles sum=0, cout=1, overflow=0 (zero=1 if CLA_ZERO_FLAG_EN).
- Subtract with borrow: A=5, B=7, sub=1, cin=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, overflow=0.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, add, cin=0 -> sum=0x8000_0000_0000_0000, overflow=1, cout=0.
- Backpressure:
  - Stimulus: stream 6 back-to-back beats (A=i, B=i), with out_ready=0 for 3 cycles after the first result.
  - Response: in_ready=0 during the stall; results 0,2,4,6,8,10 delivered in order with none lost or duplicated; the first result holds stable.
- Reset mid-flight: assert rst_n=0 with 3 beats in the pipe -> out_valid=0 immediately; after release, the next result is from the first post-reset beat only.
- Random 10k beats with random in_valid/out_ready and sub/cin, checked against a reference model {cout,sum} = A + (sub?~B:B) + cin -> zero mismatches.
